dbus_dual_sequencer: RTL and testbench

- Sequences the two memory-stage lanes of the dual-issue pipe onto the single shared data-bus port.
- Lane 0 is the older instruction and is always served first.
- Results are returned per lane, in the format the memory-stage load-extract logic consumes.
- Stalls the pipe until every valid lane completes; lane 1 can be cancelled before it issues (lane-0 exception).

---
 rtl/dbus_dual_sequencer_pkg.sv | 20 ++
 rtl/dbus_lane_slot.sv | 35 +++
 rtl/dbus_dual_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_dbus_dual_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dbus_dual_sequencer_pkg.sv
// Shared types and constants for the dual-lane data-bus sequencer.
package dbus_dual_sequencer_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'd0;
    localparam seq_state_t ST_ISSUE = 2'd1;
    localparam seq_state_t ST_WAIT  = 2'd2;
    localparam seq_state_t ST_HOLD  = 2'd3;

    // Lane 0 is the older instruction, lane 1 the younger.
    typedef logic lane_t;

    localparam int SIZE_W = 3;

    localparam logic [SIZE_W-1:0] MSIZE_BYTE = 3'd0;
    localparam logic [SIZE_W-1:0] MSIZE_HALF = 3'd1;
    localparam logic [SIZE_W-1:0] MSIZE_WORD = 3'd2;

endpackage

// File: rtl/dbus_lane_slot.sv
// Per-lane result slot: captures raw bus read data on completion, clears its
// valid flag when the pipe advances; the data itself is retained.
module dbus_lane_slot #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          done_i,
    input  logic          clear_i,
    input  logic [DW-1:0] rdata_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // NOTE: the data register is reset too, because downstream load-extract
    // logic can look at it before the first load ever returns.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (done_i) begin
            valid_q <= 1'b1;
            data_q  <= rdata_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/dbus_dual_sequencer.sv
// Serialises the two memory-stage lanes onto one data-bus port, lane 0 first.
// Define DBUS_PIPELINE_EN to let lane 1 issue before lane 0 completes.
module dbus_dual_sequencer
    import dbus_dual_sequencer_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            req_valid,
    input  logic [2*AW-1:0]       req_addr,
    input  logic [2*SIZE_W-1:0]   req_size,
    input  logic [2*(DW/8)-1:0]   req_strobe,
    input  logic [2*DW-1:0]       req_wdata,
    input  logic                  kill1,
    input  logic                  advance,
    output logic                  stall,
    output logic [1:0]            resp_valid,
    output logic [2*DW-1:0]       resp_data,
    output logic                  bus_valid,
    output logic [AW-1:0]         bus_addr,
    output logic [SIZE_W-1:0]     bus_size,
    output logic [DW/8-1:0]       bus_strobe,
    output logic [DW-1:0]         bus_wdata,
    input  logic                  bus_addr_ok,
    input  logic                  bus_data_ok,
    input  logic [DW-1:0]         bus_rdata
);

    localparam int SW = DW / 8;

    seq_state_t state_q, state_d;
    lane_t      cur_q, cur_d;
    logic       pend1_q, pend1_d;
    logic       done;
    lane_t      done_lane;
    logic       clear;
    logic       go_lane1;
    logic       lane1_issued;

`ifdef DBUS_PIPELINE_EN
    logic [1:0] outst_q, outst_d;
    lane_t      cmp_q, cmp_d;
    logic       acc;
    logic       dok;
`endif

    assign lane1_issued = cur_q && (state_q == ST_ISSUE || state_q == ST_WAIT);
    assign go_lane1     = !cur_q && pend1_q && !kill1;

    // NOTE: every variable gets its default before the case so no path
    // through this block leaves something unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        pend1_d   = pend1_q;
        done      = 1'b0;
        done_lane = cur_q;
        clear     = 1'b0;
`ifdef DBUS_PIPELINE_EN
        cmp_d     = cmp_q;
        acc       = (state_q == ST_ISSUE) && bus_addr_ok;
        dok       = bus_data_ok && (outst_q != 2'd0 || acc);
        outst_d   = outst_q + {1'b0, acc} - {1'b0, dok};
        done      = dok;
        done_lane = cmp_q;
        if (dok)
            cmp_d = 1'b1;
`endif

        // Lane 1 may be cancelled right up until it drives the bus.
        if (kill1 && !lane1_issued)
            pend1_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid[0] || (req_valid[1] && !kill1)) begin
                    pend1_d = req_valid[1] && !kill1;
                    cur_d   = !req_valid[0];
                    state_d = ST_ISSUE;
`ifdef DBUS_PIPELINE_EN
                    cmp_d   = !req_valid[0];
`endif
                end
            end
`ifdef DBUS_PIPELINE_EN
            ST_ISSUE: begin
                if (acc) begin
                    if (go_lane1)
                        cur_d = 1'b1;
                    else
                        state_d = (outst_d == 2'd0) ? ST_HOLD : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (outst_d == 2'd0)
                    state_d = ST_HOLD;
            end
`else
            ST_ISSUE: begin
                if (bus_addr_ok) begin
                    state_d = ST_WAIT;
                    if (bus_data_ok) begin
                        done    = 1'b1;
                        cur_d   = go_lane1 ? 1'b1 : cur_q;
                        state_d = go_lane1 ? ST_ISSUE : ST_HOLD;
                    end
                end
            end
            ST_WAIT: begin
                if (bus_data_ok) begin
                    done    = 1'b1;
                    cur_d   = go_lane1 ? 1'b1 : cur_q;
                    state_d = go_lane1 ? ST_ISSUE : ST_HOLD;
                end
            end
`endif
            ST_HOLD: begin
                if (advance) begin
                    clear   = 1'b1;
                    pend1_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cur_q   <= 1'b0;
            pend1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend1_q <= pend1_d;
        end
    end

`ifdef DBUS_PIPELINE_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            outst_q <= 2'd0;
            cmp_q   <= 1'b0;
        end else begin
            outst_q <= outst_d;
            cmp_q   <= cmp_d;
        end
    end
`endif

    // The request is held stable while stalled, so the payload is a plain mux.
    assign bus_valid  = (state_q == ST_ISSUE);
    assign bus_addr   = !bus_valid ? '0 : cur_q ? req_addr[2*AW-1:AW]         : req_addr[AW-1:0];
    assign bus_size   = !bus_valid ? '0 : cur_q ? req_size[2*SIZE_W-1:SIZE_W] : req_size[SIZE_W-1:0];
    assign bus_strobe = !bus_valid ? '0 : cur_q ? req_strobe[2*SW-1:SW]       : req_strobe[SW-1:0];
    assign bus_wdata  = !bus_valid ? '0 : cur_q ? req_wdata[2*DW-1:DW]        : req_wdata[DW-1:0];

    // Gating with resetn keeps stall low while reset is asserted even if
    // upstream still presents requests.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            ST_IDLE:  stall = resetn && (|req_valid);
            ST_ISSUE: stall = 1'b1;
            ST_WAIT:  stall = 1'b1;
            default:  stall = 1'b0;
        endcase
    end

    for (genvar i = 0; i < 2; i++) begin : g_slot
        dbus_lane_slot #(.DW(DW)) u_slot (
            .clk     (clk),
            .resetn  (resetn),
            .done_i  (done && (done_lane == lane_t'(i))),
            .clear_i (clear),
            .rdata_i (bus_rdata),
            .valid_o (resp_valid[i]),
            .data_o  (resp_data[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_dbus_dual_sequencer.sv
// Directed self-checking bench for dbus_dual_sequencer.
// Define DBUS_PIPELINE_EN to exercise the pipelined variant.
module tb_dbus_dual_sequencer;
    import dbus_dual_sequencer_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic                clk = 1'b0;
    logic                resetn;
    logic [1:0]          req_valid;
    logic [2*AW-1:0]     req_addr;
    logic [2*SIZE_W-1:0] req_size;
    logic [2*SW-1:0]     req_strobe;
    logic [2*DW-1:0]     req_wdata;
    logic                kill1;
    logic                advance;
    logic                stall;
    logic [1:0]          resp_valid;
    logic [2*DW-1:0]     resp_data;
    logic                bus_valid;
    logic [AW-1:0]       bus_addr;
    logic [SIZE_W-1:0]   bus_size;
    logic [SW-1:0]       bus_strobe;
    logic [DW-1:0]       bus_wdata;
    logic                bus_addr_ok;
    logic                bus_data_ok;
    logic [DW-1:0]       bus_rdata;

    int n_vec = 0;
    int n_err = 0;
    int txn_cnt = 0;
    int t0;
    int stall_cnt;

    dbus_dual_sequencer #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .req_strobe  (req_strobe),
        .req_wdata   (req_wdata),
        .kill1       (kill1),
        .advance     (advance),
        .stall       (stall),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .bus_valid   (bus_valid),
        .bus_addr    (bus_addr),
        .bus_size    (bus_size),
        .bus_strobe  (bus_strobe),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    // Count accepted bus requests, sampled mid-cycle.
    always @(negedge clk)
        if (resetn && bus_valid && bus_addr_ok)
            txn_cnt <= txn_cnt + 1;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lane(input int l, input logic [AW-1:0] a, input logic [SIZE_W-1:0] s,
                            input logic [SW-1:0] st, input logic [DW-1:0] w);
        req_addr[l*AW +: AW]         = a;
        req_size[l*SIZE_W +: SIZE_W] = s;
        req_strobe[l*SW +: SW]       = st;
        req_wdata[l*DW +: DW]        = w;
    endtask

    initial begin
        resetn = 1'b0; req_valid = '0; req_addr = '0; req_size = '0; req_strobe = '0;
        req_wdata = '0; kill1 = 1'b0; advance = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;

        #2;
        check("rst_stall", stall, 0);
        check("rst_bus_valid", bus_valid, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_payload", {bus_addr, bus_size, bus_strobe, bus_wdata}, 0);
        @(posedge clk); @(posedge clk); #1 resetn = 1'b1;

        // No request: sequencer stays idle, advance is ignored.
        cyc(); advance = 1'b1; settle();
        check("idle_stall", stall, 0);
        cyc(); advance = 1'b0; settle();
        check("idle_bus_valid", bus_valid, 0);
        check("idle_resp_valid", resp_valid, 0);

        // Lane 0 load only.
        cyc(); req_valid = 2'b01; set_lane(0, 32'h1000_0004, MSIZE_WORD, 4'h0, 32'h0); settle();
        t0 = txn_cnt; stall_cnt = int'(stall);
        check("t1_c0_stall", stall, 1);
        cyc(); bus_addr_ok = 1'b1; settle(); stall_cnt += int'(stall);
        check("t1_bus_valid", bus_valid, 1);
        check("t1_bus_addr", bus_addr, 32'h1000_0004);
        check("t1_bus_strobe", bus_strobe, 0);
        check("t1_bus_size", bus_size, MSIZE_WORD);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF; settle();
        stall_cnt += int'(stall);
        check("t1_wait_bus_valid", bus_valid, 0);
        cyc(); bus_data_ok = 1'b0; bus_rdata = '0; settle(); stall_cnt += int'(stall);
        check("t1_hold_stall", stall, 0);
        check("t1_resp_valid", resp_valid, 2'b01);
        check("t1_resp_data0", resp_data[DW-1:0], 32'hDEAD_BEEF);
        check("t1_stall_cycles", stall_cnt, 3);
        check("t1_txn", txn_cnt - t0, 1);
        advance = 1'b1;
        cyc(); advance = 1'b0; req_valid = 2'b00; settle();
        check("t1_adv_resp_valid", resp_valid, 0);
        check("t1_adv_data_kept", resp_data[DW-1:0], 32'hDEAD_BEEF);
        check("t1_adv_stall", stall, 0);

`ifndef DBUS_PIPELINE_EN
        // Both lanes: load then store.
        cyc(); req_valid = 2'b11;
        set_lane(0, 32'h100, MSIZE_WORD, 4'h0, 32'h0);
        set_lane(1, 32'h200, MSIZE_WORD, 4'hF, 32'h1234_5678); settle();
        t0 = txn_cnt;
        check("t2_c0_stall", stall, 1);
        cyc(); bus_addr_ok = 1'b1; settle();
        check("t2_l0_req", {bus_valid, bus_addr}, {1'b1, 32'h100});
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hAAAA_0001; settle();
        check("t2_wait", {stall, bus_valid}, 2'b10);
        cyc(); bus_data_ok = 1'b0; bus_addr_ok = 1'b1; settle();
        check("t2_l1_req", {bus_valid, bus_addr, bus_strobe}, {1'b1, 32'h200, 4'hF});
        check("t2_l1_wdata", bus_wdata, 32'h1234_5678);
        check("t2_mid_resp_valid", resp_valid, 2'b01);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h5555_0002; settle();
        cyc(); bus_data_ok = 1'b0; settle();
        check("t2_resp_valid", resp_valid, 2'b11);
        check("t2_resp_data", resp_data, {32'h5555_0002, 32'hAAAA_0001});
        check("t2_hold_stall", stall, 0);
        check("t2_txn", txn_cnt - t0, 2);
        advance = 1'b1;
        cyc(); advance = 1'b0; req_valid = 2'b00; settle();

        // Both lanes, lane 1 killed while lane 0 waits.
        cyc(); req_valid = 2'b11; settle(); t0 = txn_cnt;
        cyc(); bus_addr_ok = 1'b1; settle();
        check("t3_l0_addr", bus_addr, 32'h100);
        cyc(); bus_addr_ok = 1'b0; kill1 = 1'b1; settle();
        check("t3_wait", {stall, bus_valid}, 2'b10);
        cyc(); kill1 = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h0BAD_0003; settle();
        cyc(); bus_data_ok = 1'b0; settle();
        check("t3_resp_valid", resp_valid, 2'b01);
        check("t3_hold", {stall, bus_valid}, 2'b00);
        check("t3_txn", txn_cnt - t0, 1);
        advance = 1'b1;
        cyc(); advance = 1'b0; req_valid = 2'b00; settle();
`endif

        // Lane 0 store with addr_ok withheld for 5 cycles, then addr_ok and data_ok together.
        cyc(); req_valid = 2'b01; set_lane(0, 32'h300, MSIZE_HALF, 4'h3, 32'hCAFE_F00D); settle();
        for (int k = 0; k < 5; k++) begin
            cyc(); settle();
            check("t4_payload", {bus_valid, bus_addr, bus_size, bus_strobe, bus_wdata},
                  {1'b1, 32'h300, MSIZE_HALF, 4'h3, 32'hCAFE_F00D});
            check("t4_stall", stall, 1);
        end
        cyc(); bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0000_0077; settle();
        check("t4_accept_valid", bus_valid, 1);
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b0; settle();
        check("t4_hold", {stall, resp_valid}, 3'b001);
        check("t4_resp_data0", resp_data[DW-1:0], 32'h0000_0077);
        advance = 1'b1;
        cyc(); advance = 1'b0; req_valid = 2'b00; settle();

        // Lane 1 only.
        cyc(); req_valid = 2'b10; set_lane(1, 32'h600, MSIZE_BYTE, 4'h1, 32'hAB); settle();
        check("t6_c0_stall", stall, 1);
        cyc(); bus_addr_ok = 1'b1; settle();
        check("t6_l1_req", {bus_valid, bus_addr, bus_size}, {1'b1, 32'h600, MSIZE_BYTE});
        cyc(); bus_addr_ok = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'h66; settle();
        cyc(); bus_data_ok = 1'b0; settle();
        check("t6_resp_valid", resp_valid, 2'b10);
        check("t6_resp_data", resp_data, {32'h66, 32'h77});
        advance = 1'b1;
        cyc(); advance = 1'b0; req_valid = 2'b00; settle();

`ifdef DBUS_PIPELINE_EN
        // Two loads, each data_ok three cycles after its addr_ok.
        cyc(); req_valid = 2'b11;
        set_lane(0, 32'h700, MSIZE_WORD, 4'h0, 32'h0);
        set_lane(1, 32'h800, MSIZE_WORD, 4'h0, 32'h0); settle();
        cyc(); bus_addr_ok = 1'b1; settle();
        check("p_l0_req", {bus_valid, bus_addr}, {1'b1, 32'h700});
        cyc(); settle();
        check("p_l1_req", {bus_valid, bus_addr}, {1'b1, 32'h800});
        cyc(); bus_addr_ok = 1'b0; settle();
        check("p_wait", {stall, bus_valid}, 2'b10);
        cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h11; settle();
        cyc(); bus_rdata = 32'h22; settle();
        check("p_first_done", resp_valid, 2'b01);
        cyc(); bus_data_ok = 1'b0; settle();
        check("p_resp_valid", resp_valid, 2'b11);
        check("p_resp_data", resp_data, {32'h22, 32'h11});
        check("p_hold_stall", stall, 0);
        advance = 1'b1;
        cyc(); advance = 1'b0; req_valid = 2'b00; settle();
`endif

        // Reset pulsed while lane 0 waits for data.
        cyc(); req_valid = 2'b01; set_lane(0, 32'h400, MSIZE_WORD, 4'h0, 32'h0); settle();
        cyc(); bus_addr_ok = 1'b1; settle();
        cyc(); bus_addr_ok = 1'b0; settle();
        check("t5_wait_stall", stall, 1);
        resetn = 1'b0; settle();
        check("t5_rst_stall", stall, 0);
        check("t5_rst_bus_valid", bus_valid, 0);
        check("t5_rst_resp", {resp_valid, resp_data}, 0);
        check("t5_rst_payload", {bus_addr, bus_size, bus_strobe, bus_wdata}, 0);
        req_valid = 2'b00;
        cyc(); resetn = 1'b1; settle();
        cyc(); settle();
        check("t5_idle_after", {stall, bus_valid}, 2'b00);
        req_valid = 2'b01; settle();
        check("t5_idle_capture_stall", stall, 1);
        cyc(); settle();
        check("t5_reissue", {bus_valid, bus_addr}, {1'b1, 32'h400});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
